// File: rtl/ssd_scan_controller_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
// Glyphs are active-low in {g,f,e,d,c,b,a} order.
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  typedef logic [1:0] digit_idx_t;

  // Bit k set when digit k is a leading zero to be blanked; digit 0 always shows.
  function automatic logic [3:0] lz_mask(input logic [15:0] val, input logic lz);
    logic [3:0] m;
    m[3] = lz & (val[15:12] == 4'h0);
    m[2] = m[3] & (val[11:8] == 4'h0);
    m[1] = m[2] & (val[7:4] == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/ssd_scan_controller_hex_to_ssd.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_ssd
  import ssd_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    unique case (i_nib)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/ssd_scan_controller.sv
// 4-digit common-anode display scanner: synchronises the slow scan clock, steps
// one digit per rising edge and latches the shown value once per frame.
module ssd_scan_controller
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_scan_clk,
  input  logic        i_enable,
  input  logic [15:0] i_value_in,
  input  logic [3:0]  i_dp_in,
  input  logic        i_lz_blank,
  output logic [3:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic        o_frame_done
);

  if (NUM_DIGITS != 4) begin : g_bad_digits
    $error("ssd_scan_controller: NUM_DIGITS must be 4");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("ssd_scan_controller: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;
  digit_idx_t             r_idx;
  logic [15:0]            r_shadow_val;
  logic [3:0]             r_shadow_dp;
  logic                   r_shadow_lz;

  logic        w_tick;
  logic        w_wrap;
  digit_idx_t  w_nxt_idx;
  logic [15:0] w_nxt_val;
  logic [3:0]  w_nxt_dp;
  logic        w_nxt_lz;
  logic [3:0]  w_nib;
  logic [6:0]  w_glyph;
  logic [3:0]  w_blank;
  logic        w_dig_blank;
  logic [3:0]  w_an;

  assign w_tick    = r_sync[SYNC_STAGES-1] & ~r_edge;
  assign w_wrap    = w_tick & (r_idx == 2'd3);
  assign w_nxt_idx = w_tick ? ((r_idx == 2'd3) ? 2'd0 : r_idx + 2'd1) : r_idx;

  // Outputs are built from the post-edge state so the new digit appears on the tick edge.
  assign w_nxt_val   = w_wrap ? i_value_in : r_shadow_val;
  assign w_nxt_dp    = w_wrap ? i_dp_in    : r_shadow_dp;
  assign w_nxt_lz    = w_wrap ? i_lz_blank : r_shadow_lz;
  assign w_nib       = w_nxt_val[{w_nxt_idx, 2'b00} +: 4];
  assign w_blank     = lz_mask(w_nxt_val, w_nxt_lz);
  assign w_dig_blank = w_blank[w_nxt_idx];
  assign w_an        = ~(4'b0001 << w_nxt_idx);

  hex_to_ssd u_dec (
    .i_nib (w_nib),
    .o_seg (w_glyph)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync       <= '0;
      r_edge       <= 1'b0;
      r_idx        <= 2'd3;
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_shadow_lz  <= 1'b0;
      o_an         <= 4'b1111;
      o_seg        <= SEG_BLANK;
      o_dp         <= 1'b1;
      o_frame_done <= 1'b0;
    end else begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], i_scan_clk};
      r_edge       <= r_sync[SYNC_STAGES-1];
      r_idx        <= w_nxt_idx;
      r_shadow_val <= w_nxt_val;
      r_shadow_dp  <= w_nxt_dp;
      r_shadow_lz  <= w_nxt_lz;
      o_frame_done <= w_wrap;
      // Disable blanks at once; re-enable waits for the next tick to repaint.
      if (!i_enable || (w_tick && w_dig_blank)) begin
        o_an  <= 4'b1111;
        o_seg <= SEG_BLANK;
        o_dp  <= 1'b1;
      end else if (w_tick) begin
        o_an  <= w_an;
        o_seg <= w_glyph;
        o_dp  <= ~w_nxt_dp[w_nxt_idx];
      end
    end
  end

endmodule
